// File: rtl/pe_array_pkg.sv
// Shared constants and types for the 4x32 PE array
// and its result drain path.
package pe_array_pkg;

  localparam int PE_ROWS  = 4;
  localparam int PE_COLS  = 32;
  localparam int PE_RES_W = 64;
  localparam int PE_NUM   = PE_ROWS * PE_COLS;

  localparam int DRAIN_LANES = 4;
  localparam int DRAIN_BEATS = PE_NUM / DRAIN_LANES;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SNAP,
    ST_DRAIN
  } drain_state_t;

  function automatic int beat_count(input int pes,
                                    input int lanes);
    return pes / lanes;
  endfunction

endpackage

// File: rtl/pe_done_tracker.sv
// Per-PE done edge detection, sticky completion set,
// all-seen flag and sticky overrun detection.
module pe_done_tracker
  import pe_array_pkg::*;
#(
  parameter int N = PE_NUM
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] done,
  input  logic         clr,
  output logic         all_seen,
  output logic         overrun
);

  logic [N-1:0] done_q;
  logic [N-1:0] seen;
  logic [N-1:0] rise;

  assign rise     = done & ~done_q;
  assign all_seen = &(seen | rise);

  // Track done levels and accumulate first rises per tile.
  // Rises in the capture cycle belong to the captured tile
  // and are dropped together with the cleared set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_q <= '0;
      seen   <= '0;
    end else begin
      done_q <= done;
      if (clr) begin
        seen <= '0;
      end else begin
        seen <= seen | rise;
      end
    end
  end

  // A second rise before capture means a result was lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun <= 1'b0;
    end else if (!clr && |(rise & seen)) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/pe_result_drain.sv
// Snapshots a completed PE-array tile and streams it out
// LANES results per beat over a valid/ready port.
module pe_result_drain
  import pe_array_pkg::*;
#(
  parameter  int ROWS  = PE_ROWS,
  parameter  int COLS  = PE_COLS,
  parameter  int RES_W = PE_RES_W,
  parameter  int LANES = DRAIN_LANES,
  localparam int N     = ROWS * COLS,
  localparam int NB    = N / LANES,
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1,
  localparam int BW    = LANES * RES_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N*RES_W-1:0] result,
  input  logic [N-1:0]       done,
  output logic [BW-1:0]      out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [IDX_W-1:0]   out_idx,
  output logic               acc_clr,
  output logic               busy,
  output logic               overrun,
  output logic [15:0]        tile_cnt
);

  drain_state_t       state;
  logic [N*RES_W-1:0] buffer;
  logic               all_seen;
  logic               snap;
  logic               hs;
  logic [IDX_W-1:0]   idx_nxt;

  assign snap    = (state == ST_SNAP);
  assign hs      = out_valid & out_ready;
  assign idx_nxt = out_idx + 1'b1;
  assign busy    = (state != ST_WAIT);

  pe_done_tracker #(
    .N (N)
  ) u_tracker (
    .clk      (clk),
    .rstn     (rstn),
    .done     (done),
    .clr      (snap),
    .all_seen (all_seen),
    .overrun  (overrun)
  );

  // Tile FSM: wait for completion, capture, then drain.
  // out_idx doubles as the beat counter; payload is
  // registered so it holds steady under backpressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_WAIT;
      buffer    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      acc_clr   <= 1'b0;
      tile_cnt  <= '0;
    end else begin
      acc_clr <= 1'b0;
      unique case (state)
        ST_WAIT: begin
          if (all_seen) begin
            state <= ST_SNAP;
          end
        end
        ST_SNAP: begin
          buffer    <= result;
          out_data  <= result[0 +: BW];
          out_idx   <= '0;
          out_last  <= (NB == 1);
          out_valid <= 1'b1;
          acc_clr   <= 1'b1;
          state     <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (hs) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_idx   <= '0;
              out_data  <= '0;
              tile_cnt  <= tile_cnt + 16'd1;
              state     <= all_seen ? ST_SNAP : ST_WAIT;
            end else begin
              out_idx  <= idx_nxt;
              out_data <= buffer[idx_nxt*BW +: BW];
              out_last <= (idx_nxt == IDX_W'(NB - 1));
            end
          end
        end
        default: begin
          state <= ST_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_result_drain.sv
// Randomized bench for pe_result_drain with a tile
// scoreboard and per-beat payload/order checking.
`timescale 1ns/1ps
module tb_pe_result_drain;

  localparam int N  = 128;
  localparam int W  = 64;
  localparam int L  = 4;
  localparam int NB = 32;

  logic           clk;
  logic           rstn;
  logic [N*W-1:0] result;
  logic [N-1:0]   done;
  logic [L*W-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic [4:0]     out_idx;
  logic           acc_clr;
  logic           busy;
  logic           overrun;
  logic [15:0]    tile_cnt;

  pe_result_drain dut (
    .clk       (clk),
    .rstn      (rstn),
    .result    (result),
    .done      (done),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_idx   (out_idx),
    .acc_clr   (acc_clr),
    .busy      (busy),
    .overrun   (overrun),
    .tile_cnt  (tile_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [N*W-1:0] exp_q[$];
  int             mbeat = 0;
  int             tiles_done = 0;
  int             acc_cnt = 0;
  int             n_push = 0;
  logic           rand_ready = 0;
  logic           stall_pend = 0;
  logic [L*W-1:0] st_data;
  logic [4:0]     st_idx;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_tile();
    for (int p = 0; p < N; p++)
      result[p*W +: W] = {$urandom, $urandom};
  endtask

  task automatic push_tile();
    exp_q.push_back(result);
    n_push++;
  endtask

  task automatic wait_tiles(input int n);
    int k = 0;
    while (tiles_done < n && k < 2000) begin
      tick();
      k++;
    end
    check("drain_timeout", tiles_done, n);
  endtask

  task automatic wait_acc();
    int k = 0;
    while (!acc_clr && k < 50) begin
      tick();
      k++;
    end
    check("acc_timeout", acc_clr, 1);
  endtask

  task automatic wait_idx(input int v);
    int k = 0;
    while (!(out_valid && out_idx == v) && k < 500) begin
      tick();
      k++;
    end
    check("idx_timeout", out_idx, v);
  endtask

  task automatic ready_fixed();
    rand_ready = 0;
    tick();
    tick();
    out_ready = 1;
  endtask

  // Random backpressure driver.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: beat order, payload, stall stability.
  always @(negedge clk) begin
    logic [N*W-1:0] cur;
    logic [L*W-1:0] eb;
    if (!rstn) begin
      stall_pend = 0;
    end else begin
      if (acc_clr) acc_cnt++;
      check("last_flag", out_last,
            out_valid && out_idx == 5'd31);
      if (stall_pend) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, st_data);
        check("stall_idx", out_idx, st_idx);
      end
      stall_pend = out_valid && !out_ready;
      st_data = out_data;
      st_idx = out_idx;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 1, 0);
        end else begin
          cur = exp_q[0];
          for (int l = 0; l < L; l++)
            eb[l*W +: W] = cur[(mbeat*L + l)*W +: W];
          check("beat_idx", out_idx, mbeat);
          check("beat_data", out_data, eb);
          mbeat++;
          if (mbeat == NB) begin
            void'(exp_q.pop_front());
            mbeat = 0;
            tiles_done++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int perm[N];
    rstn = 0;
    done = '0;
    result = '0;
    out_ready = 0;
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_idx", out_idx, 0);
    check("rst_last", out_last, 0);
    check("rst_acc", acc_clr, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    check("rst_cnt", tile_cnt, 0);
    rstn = 1;
    tick();

    // Single tile, all done at once
    out_ready = 1;
    for (int p = 0; p < N; p++)
      result[p*W +: W] = 64'(p) * 64'h0101;
    done = '1;
    push_tile();
    tick();
    check("snap_busy", busy, 1);
    check("snap_novalid", out_valid, 0);
    tick();
    check("e2_valid", out_valid, 1);
    check("e2_acc", acc_clr, 1);
    check("e2_idx", out_idx, 0);
    check("e2_lane1", out_data[W +: W], 64'h0101);
    done = '0;
    tick();
    check("acc_once", acc_clr, 0);
    repeat (30) tick();
    check("drain_busy", busy, 1);
    check("drain_last", out_last, 1);
    tick();
    check("drain_end", busy, 0);
    wait_tiles(1);
    check("cnt_single", tile_cnt, 1);

    // Staggered done, one new PE per cycle
    rand_tile();
    for (int i = 0; i < N; i++) perm[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < N; i++) begin
      check("no_early", busy, 0);
      done[perm[i]] = 1'b1;
      if (i == N - 1) push_tile();
      tick();
    end
    check("stag_snap", busy, 1);
    check("stag_novalid", out_valid, 0);
    wait_acc();
    done = '0;
    rand_ready = 1;
    wait_tiles(2);

    // Backpressure on a random tile
    rand_tile();
    done = '1;
    push_tile();
    wait_acc();
    done = '0;
    wait_tiles(3);
    check("cnt_bp", tile_cnt, tiles_done);
    ready_fixed();

    // Back-to-back: tile B completes at beat 10 of A
    rand_tile();
    done = '1;
    push_tile();
    wait_acc();
    done = '0;
    rand_tile();
    wait_idx(10);
    done = '1;
    push_tile();
    wait_tiles(4);
    check("b2b_bubble", out_valid, 0);
    check("b2b_snap", busy, 1);
    tick();
    check("b2b_valid", out_valid, 1);
    check("b2b_acc", acc_clr, 1);
    check("b2b_idx", out_idx, 0);
    done = '0;
    wait_tiles(5);
    check("b2b_cnt", tile_cnt, 5);
    check("b2b_ovr", overrun, 0);

    // Overrun: PE 5 completes twice
    rand_tile();
    done[5] = 1'b1;
    tick();
    done[5] = 1'b0;
    tick();
    check("ovr_pre", overrun, 0);
    done[5] = 1'b1;
    tick();
    check("ovr_set", overrun, 1);
    done = '1;
    push_tile();
    wait_acc();
    done = '0;
    wait_tiles(6);
    check("ovr_sticky", overrun, 1);
    check("ovr_cnt", tile_cnt, 6);
    check("acc_count", acc_cnt, n_push);

    // Reset during beat 7
    rand_tile();
    done = '1;
    push_tile();
    wait_acc();
    done = '0;
    wait_idx(7);
    #2;
    rstn = 0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_data", out_data, 0);
    check("ar_idx", out_idx, 0);
    check("ar_last", out_last, 0);
    check("ar_busy", busy, 0);
    check("ar_ovr", overrun, 0);
    check("ar_cnt", tile_cnt, 0);
    exp_q.delete();
    mbeat = 0;
    tiles_done = 0;
    acc_cnt = 0;
    n_push = 0;
    tick();
    tick();
    rstn = 1;
    tick();
    rand_tile();
    done = '1;
    push_tile();
    wait_acc();
    done = '0;
    wait_tiles(1);
    check("post_cnt", tile_cnt, 1);
    check("post_acc", acc_cnt, n_push);
    check("q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pe_result_drain.md
# pe_result_drain

Read-side companion to the 4×32 PE array. It watches the array's per-PE `done` flags, tracks completion of a whole output tile, and snapshots the 128×64-bit flat `result` bus into a drain buffer. It then streams the tile out over a narrow valid/ready interface toward the output SRAM/writeback path, and pulses an accumulator-clear so the array can start the next tile while the drain is in progress.

## Interface
- `ROWS`, 4: PE rows; PE index = row*COLS + col.
- `COLS`, 32: PE columns.
- `RES_W`, 64: bits per PE result.
- `LANES`, 4: results per output beat; must divide ROWS*COLS.
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `result`  in  ROWS*COLS*RES_W  flat array results; PE p occupies bits [p*RES_W +: RES_W].
- `done`  in  ROWS*COLS  per-PE done level; bit p pairs with result slice p.
- `out_data`  out  LANES*RES_W  beat payload; lane l = PE (beat*LANES + l), lane 0 in the LSBs.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  downstream accept.
- `out_last`  out  1  final beat of the tile.
- `out_idx`  out  clog2(ROWS*COLS/LANES)  beat index within the tile.
- `acc_clr`  out  1  one-cycle pulse; the array may clear its accumulators.
- `busy`  out  1  high in SNAP or DRAIN.
- `overrun`  out  1  sticky error flag.
- `tile_cnt`  out  16  tiles fully drained; wraps modulo 2^16.

## Operation
- Done tracking: register `done_q`. `rise = done & ~done_q`. Sticky `seen |= rise` every cycle. A level held high therefore counts once.
- Overrun: set if any `rise & seen` bit is nonzero, which means a PE finished again before its previous result was captured. Cleared only by reset. The affected tile is still drained normally.
- FSM with three states: WAIT, SNAP, DRAIN.
  - WAIT → SNAP when `(seen | rise)` is all-ones.
  - SNAP (1 cycle):
    - Copy `result` into the buffer.
    - Clear `seen`. Rises sampled in this cycle are discarded because they belong to the captured tile.
    - Register `acc_clr` = 1 for the next cycle.
    - Go to DRAIN with beat = 0.
  - DRAIN:
    - `out_valid` = 1 and `out_data` = buffer beat `beat`.
    - On `out_valid & out_ready`, beat++.
    - On the last beat's handshake, tile_cnt++ and go to WAIT. If `(seen | rise)` is already all-ones in that cycle, go directly to SNAP instead.
- While in DRAIN, done tracking continues so the next tile accumulates in `seen`. The array holds its result until `acc_clr`, so there is no data loss apart from the overrun case.
- Reset values: state WAIT, `seen`/`done_q`/beat/tile_cnt = 0, buffer = 0, and every output 0.
- Reset asserted mid-drain aborts the tile immediately with no partial count.

## Timing
- Edge E is the first edge where all 128 done bits are seen. At E+1 the block is in SNAP; at E+2 `out_valid` = 1 and `acc_clr` = 1.
- Tile drain takes ROWS*COLS/LANES = 32 beats, so 32 cycles minimum with `out_ready` held high.
- `out_data`, `out_idx` and `out_last` are registered from the buffer and beat counter. They stay stable while `out_valid & ~out_ready`.
- `out_valid` never drops without a handshake. There is no bubble between beats when `out_ready` = 1.
- `out_last` = 1 exactly when `out_idx` = ROWS*COLS/LANES-1 and `out_valid` = 1.
- Back-to-back case: if the next tile completes during DRAIN, SNAP follows the last-beat handshake with one bubble cycle.

## Structure
- Shared `pe_array_pkg`: ROWS/COLS/RES_W constants, PE_NUM = ROWS*COLS, and the drain state enum. The array and the drain share these constants.
- One sub-module `pe_done_tracker`: holds `done_q`, the rise detect, `seen` set/clear, the all-seen flag and overrun. The FSM, buffer and beat mux live in the top.

## Test plan
- Single tile: raise `done` for all PEs at once with result[p] = p·0x0101, and hold `out_ready` = 1. Required: 32 beats; beat k lane l = (4k+l)·0x0101; `out_last` on idx 31; `acc_clr` pulses once at E+2; tile_cnt = 1.
- Staggered done: raise one PE per cycle in random order and hold some bits high throughout. Required: SNAP only after the 128th distinct rise, and no early capture.
- Backpressure: toggle `out_ready` randomly. Required: payload and idx stable while stalled, all 32 beats in order, none duplicated or dropped.
- Back-to-back: complete tile 2 during beat 10 of tile 1. Required: tile 2 snapshot one cycle after tile 1's last handshake, carrying tile-2 values; tile_cnt = 2; overrun = 0.
- Overrun: re-pulse `done[5]` before the tile is all-seen. Required: overrun = 1 and sticky, and the tile still drains.
- Reset mid-drain: deassert `rstn` at beat 7. Required: all outputs 0 asynchronously, tile_cnt = 0, and a fresh tile afterward drains correctly from beat 0.
